// File: rtl/key_matrix_scan_pkg.sv
// Shared definitions for the keypad front end: FSM states, key codes, and the default scan timing.
// The display and arithmetic blocks also use the key-code constants.
package key_matrix_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DEB_P,
      ST_SCAN,
      ST_EMIT,
      ST_DEB_R
   } kms_state_e;

   localparam int unsigned DEFAULT_SCAN_TICK_CYCLES = 24000;  // 1 ms at 24 MHz
   localparam int unsigned DEFAULT_DEBOUNCE_TICKS   = 20;

   localparam logic [3:0] KEY_0 = 4'h0;
   localparam logic [3:0] KEY_1 = 4'h1;
   localparam logic [3:0] KEY_2 = 4'h2;
   localparam logic [3:0] KEY_3 = 4'h3;
   localparam logic [3:0] KEY_4 = 4'h4;
   localparam logic [3:0] KEY_5 = 4'h5;
   localparam logic [3:0] KEY_6 = 4'h6;
   localparam logic [3:0] KEY_7 = 4'h7;
   localparam logic [3:0] KEY_8 = 4'h8;
   localparam logic [3:0] KEY_9 = 4'h9;
   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/key_matrix_scan_tick.sv
// Free-running scan tick: one-cycle pulse every SCAN_TICK_CYCLES clocks.
module key_scan_tick #(
   parameter int unsigned SCAN_TICK_CYCLES = 24000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned TW = (SCAN_TICK_CYCLES > 1) ? $clog2(SCAN_TICK_CYCLES) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == TW'(SCAN_TICK_CYCLES - 1));
      cnt_d = tick ? '0 : cnt_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: row synchronizer, press/release debounce, column scan, and one strobe per press.
// A press is accepted only when exactly one closure is found across all four columns.
module key_matrix_scan
   import key_matrix_scan_pkg::*;
#(
   parameter int unsigned SCAN_TICK_CYCLES = DEFAULT_SCAN_TICK_CYCLES,
   parameter int unsigned DEBOUNCE_TICKS   = DEFAULT_DEBOUNCE_TICKS
) (
   input  logic       CLK,
   input  logic       nRST,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] KEY_Value,
   output logic       Value_en,
   output logic       KEY_Busy
);

   localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

   logic tick;

   key_scan_tick #(
      .SCAN_TICK_CYCLES(SCAN_TICK_CYCLES)
   ) u_tick (
      .clk  (CLK),
      .rst_n(nRST),
      .tick (tick)
   );

   kms_state_e    state_q, state_d;
   logic [3:0]    row_meta_q, row_meta_d;
   logic [3:0]    row_sync_q, row_sync_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [1:0]    hit_row_q, hit_row_d;
   logic [1:0]    hit_col_q, hit_col_d;
   logic          found_q, found_d;
   logic          multi_q, multi_d;
   logic [3:0]    key_value_q, key_value_d;

   logic [3:0] row_low;
   logic       any_low;
   logic [2:0] low_cnt;
   logic [1:0] low_row;

   always_comb begin
      row_low = ~row_sync_q;
      any_low = (row_sync_q != 4'hF);
      low_cnt = '0;
      low_row = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         low_cnt = low_cnt + {2'b00, row_low[i]};
         if (row_low[i]) low_row = i[1:0];
      end
   end

   always_comb begin
      row_meta_d  = ROW;
      row_sync_d  = row_meta_q;
      state_d     = state_q;
      deb_cnt_d   = deb_cnt_q;
      col_idx_d   = col_idx_q;
      hit_row_d   = hit_row_q;
      hit_col_d   = hit_col_q;
      found_d     = found_q;
      multi_d     = multi_q;
      key_value_d = key_value_q;

      case (state_q)
         ST_IDLE: begin
            if (tick && any_low) begin
               state_d   = ST_DEB_P;
               deb_cnt_d = DW'(1);
            end
         end
         ST_DEB_P: begin
            if (tick) begin
               if (!any_low) begin
                  state_d = ST_IDLE;
               end else if (deb_cnt_q >= DEB_LAST) begin
                  state_d   = ST_SCAN;
                  col_idx_d = '0;
                  found_d   = 1'b0;
                  multi_d   = 1'b0;
               end else begin
                  deb_cnt_d = deb_cnt_q + DW'(1);
               end
            end
         end
         ST_SCAN: begin
            // The column driven during this tick window is sampled at its closing tick
            if (tick) begin
               if (low_cnt > 3'd1) begin
                  multi_d = 1'b1;
               end else if (low_cnt == 3'd1) begin
                  if (found_q) begin
                     multi_d = 1'b1;
                  end else begin
                     found_d   = 1'b1;
                     hit_row_d = low_row;
                     hit_col_d = col_idx_q;
                  end
               end
               if (col_idx_q == 2'd3) begin
                  if (multi_d) begin
                     state_d   = ST_DEB_R;
                     deb_cnt_d = '0;
                  end else if (found_d) begin
                     state_d     = ST_EMIT;
                     key_value_d = key_code(hit_row_d, hit_col_d);
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end
         end
         ST_EMIT: begin
            state_d   = ST_DEB_R;
            deb_cnt_d = '0;
         end
         ST_DEB_R: begin
            if (tick) begin
               if (any_low) begin
                  deb_cnt_d = '0;
               end else if (deb_cnt_q >= DEB_LAST) begin
                  state_d   = ST_IDLE;
                  deb_cnt_d = '0;
               end else begin
                  deb_cnt_d = deb_cnt_q + DW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         row_meta_q  <= 4'b1111;
         row_sync_q  <= 4'b1111;
         deb_cnt_q   <= '0;
         col_idx_q   <= '0;
         hit_row_q   <= '0;
         hit_col_q   <= '0;
         found_q     <= 1'b0;
         multi_q     <= 1'b0;
         key_value_q <= KEY_0;
      end else begin
         state_q     <= state_d;
         row_meta_q  <= row_meta_d;
         row_sync_q  <= row_sync_d;
         deb_cnt_q   <= deb_cnt_d;
         col_idx_q   <= col_idx_d;
         hit_row_q   <= hit_row_d;
         hit_col_q   <= hit_col_d;
         found_q     <= found_d;
         multi_q     <= multi_d;
         key_value_q <= key_value_d;
      end
   end

   always_comb begin
      COL       = (state_q == ST_SCAN) ? ~(4'b0001 << col_idx_q) : 4'b0000;
      KEY_Value = key_value_q;
      Value_en  = (state_q == ST_EMIT);
      KEY_Busy  = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_key_matrix_scan.sv
// Self-checking bench for key_matrix_scan with a resistive-short keypad model and a press-level reference.
module tb_key_matrix_scan;

   localparam int unsigned TICK = 8;
   localparam int unsigned DEB  = 3;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic [3:0] ROW;
   logic [3:0] COL;
   logic [3:0] KEY_Value;
   logic       Value_en;
   logic       KEY_Busy;

   logic [15:0] keys = '0;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int pulses = 0;
   logic [3:0] codes[$];
   int pulse_cyc[$];
   logic prev_en = 1'b0;

   key_matrix_scan #(
      .SCAN_TICK_CYCLES(TICK),
      .DEBOUNCE_TICKS  (DEB)
   ) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .ROW      (ROW),
      .COL      (COL),
      .KEY_Value(KEY_Value),
      .Value_en (Value_en),
      .KEY_Busy (KEY_Busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   // Pressed key (r,c) pulls ROW[r] low whenever COL[c] is driven low
   always_comb begin
      ROW = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
   end

   always @(negedge CLK) begin
      if (!nRST) begin
         prev_en = 1'b0;
      end else begin
         if (Value_en) begin
            checks++;
            if (prev_en) begin
               failures++;
               $display("FAIL strobe_width: Value_en high two cycles in a row at cycle %0d", cyc);
            end
            pulses++;
            codes.push_back(KEY_Value);
            pulse_cyc.push_back(cyc);
         end
         prev_en = Value_en;
      end
   end

   // Reference rule: the key must survive DEB debounce ticks, then be present when its column is sampled
   function automatic int exp_strobes(input int hold, input int col);
      return (hold >= int'(DEB) + 1 + col) ? 1 : 0;
   endfunction

   task automatic wait_ticks(input int n);
      repeat (n * TICK) @(posedge CLK);
      #1;
   endtask

   task automatic release_reset;
      @(negedge CLK) nRST = 1'b1;
      repeat (TICK) @(posedge CLK);
      #1;
   endtask

   task automatic press(input int r, input int c);
      keys[r*4+c] = 1'b1;
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      keys = '0;
      #12;
      checks++;
      if (COL !== 4'b0000) begin failures++; $display("FAIL reset_col: got %b want 0000", COL); end
      checks++;
      if (KEY_Value !== 4'h0) begin failures++; $display("FAIL reset_key: got %h want 0", KEY_Value); end
      checks++;
      if (Value_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b want 0", Value_en); end
      checks++;
      if (KEY_Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", KEY_Busy); end
      release_reset();
   endtask

   task automatic test_single_press;
      int p0, c0;
      p0 = pulses;
      c0 = cyc;
      press(2, 1);
      wait_ticks(1);
      checks++;
      if (KEY_Busy !== 1'b1) begin failures++; $display("FAIL press_busy: got %b want 1", KEY_Busy); end
      wait_ticks(39);
      keys = '0;
      wait_ticks(6);
      checks++;
      if (pulses - p0 !== 1) begin failures++; $display("FAIL hold_count: got %0d pulses want 1", pulses - p0); end
      if (pulses - p0 == 1) begin
         checks++;
         if (codes[p0] !== 4'h9) begin failures++; $display("FAIL hold_code: got %h want 9", codes[p0]); end
         checks++;
         if (pulse_cyc[p0] - c0 !== int'((DEB + 4) * TICK)) begin
            failures++;
            $display("FAIL latency: got %0d cycles want %0d", pulse_cyc[p0] - c0, (DEB + 4) * TICK);
         end
      end
      checks++;
      if (KEY_Value !== 4'h9) begin failures++; $display("FAIL hold_after: got %h want 9", KEY_Value); end
      checks++;
      if (KEY_Busy !== 1'b0) begin failures++; $display("FAIL hold_idle: got %b want 0", KEY_Busy); end
   endtask

   task automatic test_short_press;
      int p0;
      p0 = pulses;
      press(0, 0);
      wait_ticks(2);
      keys = '0;
      wait_ticks(5);
      checks++;
      if (pulses - p0 !== 0) begin failures++; $display("FAIL bounce_count: got %0d pulses want 0", pulses - p0); end
      checks++;
      if (KEY_Busy !== 1'b0) begin failures++; $display("FAIL bounce_idle: got %b want 0", KEY_Busy); end
   endtask

   task automatic test_back_to_back;
      int p0;
      p0 = pulses;
      press(3, 3);
      wait_ticks(10);
      keys = '0;
      wait_ticks(10);
      press(0, 2);
      wait_ticks(10);
      keys = '0;
      wait_ticks(6);
      checks++;
      if (pulses - p0 !== 2) begin failures++; $display("FAIL b2b_count: got %0d pulses want 2", pulses - p0); end
      if (pulses - p0 == 2) begin
         checks++;
         if (codes[p0] !== 4'hF) begin failures++; $display("FAIL b2b_first: got %h want F", codes[p0]); end
         checks++;
         if (codes[p0+1] !== 4'h2) begin failures++; $display("FAIL b2b_second: got %h want 2", codes[p0+1]); end
         checks++;
         if (pulse_cyc[p0+1] - pulse_cyc[p0] < int'((2 * DEB + 5) * TICK)) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d cycles want >= %0d", pulse_cyc[p0+1] - pulse_cyc[p0], (2 * DEB + 5) * TICK);
         end
      end
   endtask

   task automatic test_multi;
      int p0;
      p0 = pulses;
      press(1, 0);
      press(1, 3);
      wait_ticks(10);
      checks++;
      if (KEY_Busy !== 1'b1) begin failures++; $display("FAIL multi_busy: got %b want 1", KEY_Busy); end
      keys = '0;
      wait_ticks(3);
      checks++;
      if (KEY_Busy !== 1'b0) begin failures++; $display("FAIL multi_idle: got %b want 0", KEY_Busy); end
      checks++;
      if (pulses - p0 !== 0) begin failures++; $display("FAIL multi_count: got %0d pulses want 0", pulses - p0); end
   endtask

   task automatic test_release_bounce;
      int p0;
      p0 = pulses;
      press(1, 1);
      wait_ticks(10);
      for (int i = 0; i < 6; i++) begin
         keys[5] = (i % 2 == 1);
         wait_ticks(1);
      end
      keys = '0;
      wait_ticks(6);
      checks++;
      if (pulses - p0 !== 1) begin failures++; $display("FAIL rel_bounce_count: got %0d pulses want 1", pulses - p0); end
      if (pulses - p0 == 1) begin
         checks++;
         if (codes[p0] !== 4'h5) begin failures++; $display("FAIL rel_bounce_code: got %h want 5", codes[p0]); end
      end
   endtask

   task automatic test_reset_mid_scan;
      int p0;
      press(2, 2);
      wait_ticks(4);
      checks++;
      if (COL !== 4'b1101) begin failures++; $display("FAIL scan_col: got %b want 1101", COL); end
      #2 nRST = 1'b0;
      #1;
      checks++;
      if (COL !== 4'b0000) begin failures++; $display("FAIL midrst_col: got %b want 0000", COL); end
      checks++;
      if (Value_en !== 1'b0) begin failures++; $display("FAIL midrst_en: got %b want 0", Value_en); end
      checks++;
      if (KEY_Value !== 4'h0) begin failures++; $display("FAIL midrst_key: got %h want 0", KEY_Value); end
      checks++;
      if (KEY_Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", KEY_Busy); end
      keys = '0;
      repeat (3) @(posedge CLK);
      release_reset();
      p0 = pulses;
      press(2, 2);
      wait_ticks(10);
      keys = '0;
      wait_ticks(6);
      checks++;
      if (pulses - p0 !== 1) begin failures++; $display("FAIL post_rst_count: got %0d pulses want 1", pulses - p0); end
      if (pulses - p0 == 1) begin
         checks++;
         if (codes[p0] !== 4'hA) begin failures++; $display("FAIL post_rst_code: got %h want A", codes[p0]); end
      end
   endtask

   task automatic test_random;
      int p0, r, c, hold, want;
      for (int n = 0; n < 16; n++) begin
         r = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 3));
         hold = int'($urandom_range(1, 12));
         want = exp_strobes(hold, c);
         p0 = pulses;
         press(r, c);
         wait_ticks(hold);
         keys = '0;
         wait_ticks(8);
         checks++;
         if (pulses - p0 !== want) begin
            failures++;
            $display("FAIL rand_count: key r%0d c%0d hold %0d got %0d pulses want %0d", r, c, hold, pulses - p0, want);
         end
         if (want == 1 && pulses - p0 == 1) begin
            checks++;
            if (codes[p0] !== 4'(r * 4 + c)) begin
               failures++;
               $display("FAIL rand_code: got %h want %h", codes[p0], 4'(r * 4 + c));
            end
         end
         checks++;
         if (KEY_Busy !== 1'b0) begin failures++; $display("FAIL rand_idle: got %b want 0", KEY_Busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_short_press();
      test_back_to_back();
      test_multi();
      test_release_bounce();
      test_reset_mid_scan();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
